// File: rtl/lsu_wb.sv
// Load/store unit with writeback: one instruction in flight, EXU handshake
// on the input side, request/response memory port, single GPR write port.
module lsu_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_mem_ren,
  input  logic                  in_mem_wen,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  commit,
  output logic                  lsu_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, WB
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]         addr_q;
  logic [DW-1:0]         sdata_q;
  logic [DW-1:0]         rdata_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic                  ld_q;
  logic                  st_q;
  logic                  err_q;
  logic [2:0]            f3_q;

  logic accept;
  logic ld_in, st_in, mem_in;
  logic ill_in, mis_in, err_in;

  assign accept = in_valid && (state_q == IDLE);

  // Load wins when both enables are set
  always_comb begin
    ld_in  = in_mem_ren;
    st_in  = in_mem_wen && !in_mem_ren;
    mem_in = ld_in || st_in;
    ill_in = 1'b1;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: ill_in = 1'b0;
      3'b100, 3'b101:         ill_in = !ld_in;
      default:                ill_in = 1'b1;
    endcase
    mis_in = ((in_funct3[1:0] == 2'b01) && in_alu_result[0])
          || ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00));
    err_in = mem_in && (ill_in || mis_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= in_alu_result;
        sdata_q  <= in_store_data;
        rd_q     <= in_rd;
        rd_wen_q <= in_rd_wen;
        ld_q     <= ld_in;
        st_q     <= st_in;
        err_q    <= err_in;
        f3_q     <= in_funct3;
      end
      if (state_q == WAIT && mem_resp_valid) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (mem_in && !err_in) ? REQ : WB;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) state_d = WB;
      WB:   state_d = IDLE;
    endcase
  end

  logic [NB-1:0] mask;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld_data;

  always_comb begin
    unique case (f3_q[1:0])
      2'b00: begin
        mask      = NB'(1) << addr_q[1:0];
        mem_wdata = {NB{sdata_q[7:0]}};
      end
      2'b01: begin
        mask      = NB'(3) << addr_q[1:0];
        mem_wdata = {(NB/2){sdata_q[15:0]}};
      end
      default: begin
        mask      = '1;
        mem_wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    shifted = rdata_q >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{(DW-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(DW-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(DW-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = {addr_q[DW-1:2], 2'b00};
  assign mem_wen       = (state_q == REQ) && st_q;
  assign mem_wmask     = mem_wen ? mask : '0;

  assign commit    = (state_q == WB);
  assign lsu_err   = commit && err_q;
  assign gpr_wen   = commit && rd_wen_q && (rd_q != '0) && !st_q && !err_q;
  assign gpr_waddr = rd_q;
  assign gpr_wdata = ld_q ? ld_data : addr_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: vector table of single ops plus
// stall and mid-operation reset sequences.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_mem_ren;
  logic        in_mem_wen;
  logic [2:0]  in_funct3;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        commit;
  logic        lsu_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
    .in_funct3(in_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .commit(commit), .lsu_err(lsu_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rdw;
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwd;
    logic        mwen;
    logic        gwen;
    logic [31:0] gwd;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input vec_t v);
    in_valid      = 1'b1;
    in_alu_result = v.alu;
    in_store_data = v.sd;
    in_rd         = v.rd;
    in_rd_wen     = v.rdw;
    in_mem_ren    = v.ren;
    in_mem_wen    = v.wen;
    in_funct3     = v.f3;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, ".in_ready"}, 32'(in_ready), 32'd1);
    drive_op(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk({t, ".req_valid"}, 32'(mem_req_valid), 32'(v.req));
    if (v.req) begin
      chk({t, ".mem_addr"}, mem_addr, v.maddr);
      chk({t, ".wmask"}, 32'(mem_wmask), 32'(v.mask));
      chk({t, ".mem_wen"}, 32'(mem_wen), 32'(v.mwen));
      if (v.mwen) chk({t, ".mem_wdata"}, mem_wdata, v.mwd);
      chk({t, ".commit_early"}, 32'(commit), 32'd0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({t, ".req_drop"}, 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b1;
      mem_rdata      = v.rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0;
    end
    chk({t, ".commit"}, 32'(commit), 32'd1);
    chk({t, ".gpr_wen"}, 32'(gpr_wen), 32'(v.gwen));
    chk({t, ".lsu_err"}, 32'(lsu_err), 32'(v.err));
    chk({t, ".gpr_waddr"}, 32'(gpr_waddr), 32'(v.rd));
    if (!v.err) chk({t, ".gpr_wdata"}, gpr_wdata, v.gwd);
    @(negedge clk);
    chk({t, ".commit_pulse"}, 32'(commit), 32'd0);
  endtask

  vec_t sh;
  vec_t lw;
  vec_t alu;

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_alu_result  = '0;
    in_store_data  = '0;
    in_rd          = '0;
    in_rd_wen      = 1'b0;
    in_mem_ren     = 1'b0;
    in_mem_wen     = 1'b0;
    in_funct3      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    vecs[0]  = '{32'h1234, 0, 5, 1, 0, 0, 3'b000, 0,
                 0, 0, 0, 0, 0, 1, 32'h1234, 0};
    vecs[1]  = '{32'h80000003, 0, 7, 1, 1, 0, 3'b000, 32'h80FF0000,
                 1, 32'h80000000, 0, 0, 0, 1, 32'hFFFFFF80, 0};
    vecs[2]  = '{32'h101, 0, 3, 1, 1, 0, 3'b100, 32'h11228344,
                 1, 32'h100, 0, 0, 0, 1, 32'h83, 0};
    vecs[3]  = '{32'h202, 0, 4, 1, 1, 0, 3'b001, 32'h80010000,
                 1, 32'h200, 0, 0, 0, 1, 32'hFFFF8001, 0};
    vecs[4]  = '{32'h200, 0, 0, 1, 1, 0, 3'b101, 32'h1234ABCD,
                 1, 32'h200, 0, 0, 0, 0, 32'hABCD, 0};
    vecs[5]  = '{32'h1000, 0, 9, 1, 1, 0, 3'b010, 32'hDEADBEEF,
                 1, 32'h1000, 0, 0, 0, 1, 32'hDEADBEEF, 0};
    vecs[6]  = '{32'h103, 32'hA5, 6, 1, 0, 1, 3'b000, 0,
                 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1, 0, 32'h103, 0};
    vecs[7]  = '{32'h40, 32'hCAFEF00D, 6, 0, 0, 1, 3'b010, 0,
                 1, 32'h40, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h40, 0};
    vecs[8]  = '{32'h2, 0, 8, 1, 1, 0, 3'b010, 0,
                 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{32'h1, 32'h55, 8, 1, 0, 1, 3'b001, 0,
                 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{32'h10, 0, 8, 1, 1, 0, 3'b011, 0,
                 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{32'h10, 32'h5, 8, 1, 0, 1, 3'b100, 0,
                 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{32'h3, 32'hFFFF, 10, 1, 1, 1, 3'b100, 32'h7F000000,
                 1, 32'h0, 0, 0, 0, 1, 32'h7F, 0};
    vecs[13] = '{32'h99, 0, 11, 0, 0, 0, 3'b000, 0,
                 0, 0, 0, 0, 0, 0, 32'h99, 0};

    // reset state, with an op offered while rst is high
    @(negedge clk);
    alu = vecs[0];
    drive_op(alu);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.commit", 32'(commit), 32'd0);
    chk("rst.gpr_wen", 32'(gpr_wen), 32'd0);
    chk("rst.gpr_wdata", gpr_wdata, 32'd0);
    chk("rst.gpr_waddr", 32'(gpr_waddr), 32'd0);
    chk("rst.mem_wmask", 32'(mem_wmask), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst.no_accept", 32'(commit), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // SH with request stalled three cycles
    sh = '{32'h102, 32'hABCD1234, 12, 1, 0, 1, 3'b001, 0,
           1, 32'h100, 4'b1100, 32'h12341234, 1, 0, 0, 0};
    @(negedge clk);
    drive_op(sh);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sh.stall%0d.valid", c), 32'(mem_req_valid), 32'd1);
      chk($sformatf("sh.stall%0d.addr", c), mem_addr, 32'h100);
      chk($sformatf("sh.stall%0d.mask", c), 32'(mem_wmask), 32'hC);
      chk($sformatf("sh.stall%0d.wdata", c), mem_wdata, 32'h12341234);
      chk($sformatf("sh.stall%0d.wen", c), 32'(mem_wen), 32'd1);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("sh.commit", 32'(commit), 32'd1);
    chk("sh.gpr_wen", 32'(gpr_wen), 32'd0);
    chk("sh.lsu_err", 32'(lsu_err), 32'd0);

    // reset during WAIT, then a late response
    lw = '{32'h500, 0, 13, 1, 1, 0, 3'b010, 0,
           0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    drive_op(lw);
    @(negedge clk);
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("abort.in_wait", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort.req_valid", 32'(mem_req_valid), 32'd0);
    chk("abort.commit", 32'(commit), 32'd0);
    chk("abort.gpr_wen", 32'(gpr_wen), 32'd0);
    chk("abort.gpr_waddr", 32'(gpr_waddr), 32'd0);
    chk("abort.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort.late%0d.commit", c), 32'(commit), 32'd0);
      chk($sformatf("abort.late%0d.ready", c), 32'(in_ready), 32'd1);
    end
    mem_resp_valid = 1'b0;

    // normal op still works after abort
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
